// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the KGP-RISC core.
// Produces datapath and memory strobes, counts retired instructions and traps on illegal opcodes or memory timeouts.
module multicycle_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       opcode,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             reg_write,
    input  logic [2:0]       branch_op,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             alu_en,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_we,
    output logic             pc_write,
    output logic             busy,
    output logic             halted,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_ILLEGAL = 2'd1,
        FC_IMEM_TO = 2'd2,
        FC_DMEM_TO = 2'd3
    } fault_code_t;

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    fault_code_t       fault_code_q, fault_code_d;

    // Decoder outputs captured in DECODE so EXEC/MEM/WB are immune to IR-side changes.
    logic mem_read_q, mem_read_d;
    logic mem_write_q, mem_write_d;
    logic reg_write_q, reg_write_d;
    logic branch_q, branch_d;

    logic opcode_legal;
    logic retire;

    always_comb begin
        case (opcode)
            5'd0, 5'd1, 5'd2, 5'd5, 5'd6, 5'd7,
            5'd8, 5'd9, 5'd10, 5'd11, 5'd13, 5'd31: opcode_legal = 1'b1;
            default:                                opcode_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        fault_code_d = fault_code_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        reg_write_d  = reg_write_q;
        branch_d     = branch_q;
        imem_req     = 1'b0;
        ir_write     = 1'b0;
        alu_en       = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        reg_we       = 1'b0;
        pc_write     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    fault_code_d = FC_IMEM_TO;
                    state_d      = S_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                mem_read_d  = mem_read;
                mem_write_d = mem_write;
                reg_write_d = reg_write;
                branch_d    = (branch_op != 3'd0);
                if (!opcode_legal) begin
                    fault_code_d = FC_ILLEGAL;
                    state_d      = S_FAULT;
                end else if (opcode == 5'd31) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_en = 1'b1;
                if (mem_read_q || mem_write_q) begin
                    state_d = S_MEM;
                end else if (branch_q && !reg_write_q) begin
                    pc_write = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = mem_write_q;
                if (dmem_ready) begin
                    if (mem_write_q) begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    fault_code_d = FC_DMEM_TO;
                    state_d      = S_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_WB: begin
                reg_we   = reg_write_q;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            default: ; // HALT and FAULT leave only through reset
        endcase

        // Every state change restarts the wait counter, covering entry to FETCH and MEM.
        if (state_d != state_q) wait_cnt_d = '0;
    end

    assign retire    = pc_write;
    assign retired_d = retire ? retired_q + 1'b1 : retired_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= '0;
            retired_q    <= '0;
            fault_code_q <= FC_NONE;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            branch_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            retired_q    <= retired_d;
            fault_code_q <= fault_code_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            reg_write_q  <= reg_write_d;
            branch_q     <= branch_d;
        end
    end

    assign busy       = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_FAULT);
    assign halted     = (state_q == S_HALT);
    assign fault      = (state_q == S_FAULT);
    assign fault_code = fault_code_q;
    assign retired    = retired_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer (TIMEOUT = 4).
// Strobe vector order: imem_req ir_write alu_en dmem_req dmem_we reg_we pc_write busy halted fault.
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [4:0]  opcode;
    logic        mem_read, mem_write, reg_write;
    logic [2:0]  branch_op;
    logic        imem_ready, dmem_ready;
    logic        imem_req, ir_write, alu_en, dmem_req, dmem_we, reg_we, pc_write;
    logic        busy, halted, fault;
    logic [1:0]  fault_code;
    logic [31:0] retired;
    logic [2:0]  state_o;
    logic [9:0]  strobes;

    int vectors     = 0;
    int miscompares = 0;

    multicycle_sequencer #(.TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .branch_op(branch_op), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_write(ir_write), .alu_en(alu_en),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_we(reg_we),
        .pc_write(pc_write), .busy(busy), .halted(halted), .fault(fault),
        .fault_code(fault_code), .retired(retired), .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign strobes = {imem_req, ir_write, alu_en, dmem_req, dmem_we,
                      reg_we, pc_write, busy, halted, fault};

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and park just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic set_dec(input logic [4:0] op, input logic mr, input logic mw,
                           input logic rw, input logic [2:0] br);
        opcode = op; mem_read = mr; mem_write = mw; reg_write = rw; branch_op = br;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        set_dec(5'd0, 1'b0, 1'b0, 1'b0, 3'd0);
        tick(); tick();
        check("reset_state", 32'(state_o), 32'd0);
        check("reset_strobes", 32'(strobes), 32'b0);
        check("reset_retired", retired, 32'd0);
        check("reset_fcode", 32'(fault_code), 32'd0);

        // ALU op, zero-wait memories: 1,2,3,5,1
        rst = 1'b0; start = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
        set_dec(5'd0, 1'b0, 1'b0, 1'b1, 3'd0);
        tick(); start = 1'b0; settle();
        check("alu_fetch_state", 32'(state_o), 32'd1);
        check("alu_fetch_strb", 32'(strobes), 32'b1100000100);
        tick();
        check("alu_decode_state", 32'(state_o), 32'd2);
        check("alu_decode_strb", 32'(strobes), 32'b0000000100);
        tick();
        check("alu_exec_state", 32'(state_o), 32'd3);
        check("alu_exec_strb", 32'(strobes), 32'b0010000100);
        tick();
        check("alu_wb_state", 32'(state_o), 32'd5);
        check("alu_wb_strb", 32'(strobes), 32'b0000011100);
        check("alu_wb_retired", retired, 32'd0);
        tick();
        check("alu_back_fetch", 32'(state_o), 32'd1);
        check("alu_retired", retired, 32'd1);

        // Load, dmem_ready on the 4th MEM cycle (boundary of TIMEOUT=4)
        set_dec(5'd5, 1'b1, 1'b0, 1'b1, 3'd0); dmem_ready = 1'b0;
        tick(); tick();
        check("ld_exec_state", 32'(state_o), 32'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("ld_mem_wait%0d_state", i), 32'(state_o), 32'd4);
            check($sformatf("ld_mem_wait%0d_strb", i), 32'(strobes), 32'b0001000100);
        end
        tick(); dmem_ready = 1'b1; settle();
        check("ld_mem_ready_state", 32'(state_o), 32'd4);
        check("ld_mem_ready_strb", 32'(strobes), 32'b0001000100);
        tick();
        check("ld_wb_state", 32'(state_o), 32'd5);
        check("ld_wb_strb", 32'(strobes), 32'b0000011100);
        tick();
        check("ld_back_fetch", 32'(state_o), 32'd1);
        check("ld_retired", retired, 32'd2);

        // Store retires from MEM, reg_we never set
        set_dec(5'd6, 1'b0, 1'b1, 1'b0, 3'd0);
        tick(); tick();
        check("st_exec_strb", 32'(strobes), 32'b0010000100);
        tick();
        check("st_mem_state", 32'(state_o), 32'd4);
        check("st_mem_strb", 32'(strobes), 32'b0001101100);
        tick();
        check("st_back_fetch", 32'(state_o), 32'd1);
        check("st_retired", retired, 32'd3);

        // Branch retires from EXEC in 3 cycles
        set_dec(5'd8, 1'b0, 1'b0, 1'b0, 3'd2);
        tick(); tick();
        check("br_exec_state", 32'(state_o), 32'd3);
        check("br_exec_strb", 32'(strobes), 32'b0010001100);
        tick();
        check("br_back_fetch", 32'(state_o), 32'd1);
        check("br_retired", retired, 32'd4);

        // Call goes via WB; decoder inputs change after DECODE and must be ignored
        set_dec(5'd9, 1'b0, 1'b0, 1'b1, 3'd3);
        tick();
        check("call_decode_state", 32'(state_o), 32'd2);
        tick(); set_dec(5'd3, 1'b1, 1'b1, 1'b0, 3'd0); settle();
        check("call_exec_state", 32'(state_o), 32'd3);
        tick(); imem_ready = 1'b0; settle();
        check("call_wb_state", 32'(state_o), 32'd5);
        check("call_wb_strb", 32'(strobes), 32'b0000011100);

        // imem timeout: 4 request cycles then FAULT code 2
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("imto_fetch%0d_strb", i), 32'(strobes), 32'b1000000100);
        end
        check("call_retired", retired, 32'd5);
        tick();
        check("imto_state", 32'(state_o), 32'd7);
        check("imto_fcode", 32'(fault_code), 32'd2);
        check("imto_strb", 32'(strobes), 32'b0000000001);
        start = 1'b1;
        tick();
        check("imto_start_ignored", 32'(state_o), 32'd7);

        // Reset, then ready on the 4th fetch cycle; opcode 3 is illegal
        rst = 1'b1; start = 1'b0;
        tick();
        check("rst_from_fault_state", 32'(state_o), 32'd0);
        check("rst_from_fault_fcode", 32'(fault_code), 32'd0);
        rst = 1'b0; start = 1'b1; set_dec(5'd3, 1'b0, 1'b0, 1'b0, 3'd0);
        tick(); start = 1'b0;
        tick(); tick();
        tick(); imem_ready = 1'b1; settle();
        check("im4_fetch_state", 32'(state_o), 32'd1);
        check("im4_ir_write", 32'(ir_write), 32'd1);
        tick();
        check("im4_decode_state", 32'(state_o), 32'd2);
        tick();
        check("ill_state", 32'(state_o), 32'd7);
        check("ill_fcode", 32'(fault_code), 32'd1);
        check("ill_strb", 32'(strobes), 32'b0000000001);
        start = 1'b1;
        tick();
        check("ill_start_ignored", 32'(state_o), 32'd7);
        rst = 1'b1; start = 1'b0;
        tick();
        check("ill_rst_state", 32'(state_o), 32'd0);
        check("ill_rst_strb", 32'(strobes), 32'b0);
        check("ill_rst_fcode", 32'(fault_code), 32'd0);
        check("ill_rst_retired", retired, 32'd0);

        // Halt
        rst = 1'b0; start = 1'b1; set_dec(5'd31, 1'b0, 1'b0, 1'b0, 3'd0);
        tick(); start = 1'b0; tick(); tick();
        check("halt_state", 32'(state_o), 32'd6);
        check("halt_strb", 32'(strobes), 32'b0000000010);
        start = 1'b1;
        tick();
        check("halt_start_ignored", 32'(state_o), 32'd6);

        // dmem timeout during a load: FAULT code 3
        rst = 1'b1; start = 1'b0; tick();
        rst = 1'b0; start = 1'b1; dmem_ready = 1'b0;
        set_dec(5'd5, 1'b1, 1'b0, 1'b1, 3'd0);
        tick(); start = 1'b0; tick(); tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("dmto_mem%0d_state", i), 32'(state_o), 32'd4);
        end
        tick();
        check("dmto_state", 32'(state_o), 32'd7);
        check("dmto_fcode", 32'(fault_code), 32'd3);

        // One ALU retire, then reset asserted mid-MEM of a load
        rst = 1'b1; tick();
        rst = 1'b0; start = 1'b1; dmem_ready = 1'b1;
        set_dec(5'd1, 1'b0, 1'b0, 1'b1, 3'd0);
        tick(); start = 1'b0; tick(); tick(); tick();
        set_dec(5'd5, 1'b1, 1'b0, 1'b1, 3'd0); dmem_ready = 1'b0;
        tick();
        check("midrst_pre_retired", retired, 32'd1);
        tick(); tick(); tick();
        check("midrst_in_mem", 32'(state_o), 32'd4);
        rst = 1'b1;
        tick();
        check("midrst_state", 32'(state_o), 32'd0);
        check("midrst_dmem_req", 32'(dmem_req), 32'd0);
        check("midrst_retired", retired, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
